hi_lo_unit: RTL and testbench

Multi-cycle HI/LO register unit in the execute stage, directly downstream of the instruction controller. It consumes the controller's `HI_LO_Write` encoding plus a decoded sub-operation and performs mult, multu, madd, msub, mthi and mtlo on rs/rt operands. It holds the architectural HI and LO registers read by mfhi/mflo, and raises `Busy` so the pipeline stalls during multi-cycle products.

---
 rtl/hi_lo_unit.sv | 111 +++++++++++
 tb/tb_hi_lo_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_unit.sv
// HI/LO register unit: multi-cycle mult/multu (plus madd/msub when HILO_ACCUM_EN is defined)
// and single-cycle mthi/mtlo; all outputs registered, Busy stalls issue while a product is pending.
module hi_lo_unit #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HI_LO_Write,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {StIdle, StMul} state_t;

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_ACCUM_EN
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
`endif
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  mask_q;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] result;
    logic        mul_issue;

`ifdef HILO_ACCUM_EN
    assign mul_issue = Start & ~Op[2];
`else
    // 010/011 are reserved in this build, so only mult/multu start a product
    assign mul_issue = Start & (Op[2:1] == 2'b00);
`endif

    // Sign/zero extension up front keeps the low 64 product bits exact for both forms
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    always_comb begin
        result = prod_s;
        case (op_q)
            OP_MULTU: result = prod_u;
`ifdef HILO_ACCUM_EN
            // HI/LO cannot change while busy, so the live value is the issue-time accumulator
            OP_MADD:  result = {HI, LO} + prod_s;
            OP_MSUB:  result = {HI, LO} - prod_s;
`endif
            default:  result = prod_s;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= StIdle;
            cnt    <= 3'd0;
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            mask_q <= 2'd0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                StIdle: begin
                    if (mul_issue) begin
                        op_q   <= Op;
                        a_q    <= A;
                        b_q    <= B;
                        mask_q <= HI_LO_Write;
                        cnt    <= CNT_INIT;
                        Busy   <= 1'b1;
                        state  <= StMul;
                    end else if (Start && Op == OP_MTHI && HI_LO_Write[0]) begin
                        HI <= A;
                    end else if (Start && Op == OP_MTLO && HI_LO_Write[1]) begin
                        LO <= A;
                    end
                end
                StMul: begin
                    if (cnt == 3'd0) begin
                        if (mask_q[0]) HI <= result[63:32];
                        if (mask_q[1]) LO <= result[31:0];
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// Bench for hi_lo_unit: cycle-level arithmetic model checked every cycle, plus directed
// literal expectations; honours HILO_ACCUM_EN the same way the design does.
module tb_hi_lo_unit;

    localparam int unsigned LAT = 4;
`ifdef HILO_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [1:0]  HI_LO_Write = 2'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    hi_lo_unit #(.LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HI_LO_Write(HI_LO_Write), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc,
                                               input bit upper);
        longint sa, sb;
        longint unsigned ua, ub, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd1:    r = ua * ub;
            3'd2:    r = acc + sa * sb;
            3'd3:    r = acc - sa * sb;
            default: r = sa * sb;
        endcase
        return upper ? r[63:32] : r[31:0];
    endfunction

    // Model: cycles remaining until commit, and the architectural HI/LO
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
    logic [2:0]  m_op = 3'd0;
    logic [1:0]  m_mask = 2'd0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                if (m_left == 1) begin
                    if (m_mask[0]) m_hi <= model_word(m_op, m_a, m_b, {m_hi, m_lo}, 1'b1);
                    if (m_mask[1]) m_lo <= model_word(m_op, m_a, m_b, {m_hi, m_lo}, 1'b0);
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (Start) begin
                if (Op < 3'd2 || (ACC && Op < 3'd4)) begin
                    m_left <= LAT;
                    m_op   <= Op;
                    m_a    <= A;
                    m_b    <= B;
                    m_mask <= HI_LO_Write;
                end else if (Op == 3'd4 && HI_LO_Write[0]) begin
                    m_hi <= A;
                end else if (Op == 3'd5 && HI_LO_Write[1]) begin
                    m_lo <= A;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("model_busy", {63'd0, Busy}, {63'd0, m_left != 0});
            check("model_done", {63'd0, Done}, {63'd0, m_done});
            check("model_hi", {32'd0, HI}, {32'd0, m_hi});
            check("model_lo", {32'd0, LO}, {32'd0, m_lo});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m);
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        HI_LO_Write = m;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
            else if (Busy) nbusy++;
        end
    endtask

    task automatic watch(input int n, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (Busy) nb++;
            if (Done) nd++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, nd;
        bit seen;

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge Clk);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);

        // Signed multiply: -3 * 7
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 2'd3);
        wait_done(nb, seen);
        check("mult_done_seen", {63'd0, seen}, 64'd1);
        check("mult_busy_cycles", 64'(nb), 64'd4);
        check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, LO}, 64'hFFFF_FFEB);
        @(negedge Clk);
        check("mult_done_fall", {63'd0, Done}, 64'd0);

        // Unsigned multiply
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 2'd3);
        wait_done(nb, seen);
        check("multu_hi", {32'd0, HI}, 64'h1);
        check("multu_lo", {32'd0, LO}, 64'hFFFF_FFFE);

        // Accumulate from HI=0, LO=5
        issue(3'd4, 32'd0, 32'd0, 2'd1);
        issue(3'd5, 32'd5, 32'd0, 2'd2);
        issue(3'd2, 32'd3, 32'd4, 2'd3);
`ifdef HILO_ACCUM_EN
        wait_done(nb, seen);
        check("madd_hi", {32'd0, HI}, 64'h0);
        check("madd_lo", {32'd0, LO}, 64'h11);
`else
        watch(6, nb, nd);
        check("madd_ignored_busy", 64'(nb), 64'd0);
        check("madd_ignored_hi", {32'd0, HI}, 64'h0);
        check("madd_ignored_lo", {32'd0, LO}, 64'h5);
`endif

        // Subtract from HI=LO=0
        issue(3'd5, 32'd0, 32'd0, 2'd2);
        issue(3'd3, 32'd1, 32'd1, 2'd3);
`ifdef HILO_ACCUM_EN
        wait_done(nb, seen);
        check("msub_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("msub_lo", {32'd0, LO}, 64'hFFFF_FFFF);
`else
        watch(6, nb, nd);
        check("msub_ignored_busy", 64'(nb), 64'd0);
        check("msub_ignored_lo", {32'd0, LO}, 64'h0);
`endif

        // MTHI with HI-only mask
        issue(3'd4, 32'h1234_5678, 32'd0, 2'd1);
        @(negedge Clk);
        check("mthi_hi", {32'd0, HI}, 64'h1234_5678);
`ifdef HILO_ACCUM_EN
        check("mthi_lo_kept", {32'd0, LO}, 64'hFFFF_FFFF);
`else
        check("mthi_lo_kept", {32'd0, LO}, 64'h0);
`endif
        check("mthi_busy", {63'd0, Busy}, 64'd0);

        // Reserved opcode
        issue(3'd6, 32'd1, 32'd1, 2'd3);
        watch(6, nb, nd);
        check("reserved_busy", 64'(nb), 64'd0);

        // Second Start while busy is dropped
        issue(3'd0, 32'd2, 32'd3, 2'd3);
        Start = 1'b1;
        Op = 3'd0;
        A = 32'd5;
        B = 32'd5;
        @(posedge Clk);
        #1 Start = 1'b0;
        wait_done(nb, seen);
        check("busy_start_cycles", 64'(nb), 64'd3);
        check("busy_start_hi", {32'd0, HI}, 64'h0);
        check("busy_start_lo", {32'd0, LO}, 64'h6);

        // Back-to-back issue in the Done cycle: -1 * -1
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3);
        wait_done(nb, seen);
        check("b2b_done_seen", {63'd0, seen}, 64'd1);
        check("b2b_busy_cycles", 64'(nb), 64'd4);
        check("b2b_hi", {32'd0, HI}, 64'h0);
        check("b2b_lo", {32'd0, LO}, 64'h1);

        // Reset in the second busy cycle
        issue(3'd0, 32'h0001_0000, 32'h0001_0000, 2'd3);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_mid_hi", {32'd0, HI}, 64'h0);
        check("rst_mid_lo", {32'd0, LO}, 64'h0);
        check("rst_mid_busy", {63'd0, Busy}, 64'd0);
        watch(8, nb, nd);
        check("rst_mid_no_done", 64'(nd), 64'd0);

        // LO-only mask
        issue(3'd4, 32'hAAAA_0000, 32'd0, 2'd3);
        issue(3'd5, 32'h55, 32'd0, 2'd3);
        issue(3'd0, 32'h0001_0000, 32'h0001_0000, 2'd2);
        wait_done(nb, seen);
        check("mask2_hi_kept", {32'd0, HI}, 64'hAAAA_0000);
        check("mask2_lo", {32'd0, LO}, 64'h0);

        // Mask 0: Done still pulses, nothing written
        issue(3'd5, 32'h77, 32'd0, 2'd2);
        issue(3'd0, 32'd3, 32'd3, 2'd0);
        wait_done(nb, seen);
        check("mask0_done_seen", {63'd0, seen}, 64'd1);
        check("mask0_busy_cycles", 64'(nb), 64'd4);
        check("mask0_hi", {32'd0, HI}, 64'hAAAA_0000);
        check("mask0_lo", {32'd0, LO}, 64'h77);

        @(negedge Clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
